// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bus for the fetch stage
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemRData;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemReady,
    input  ImemRData
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemReady,
    output ImemRData
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, multi-cycle imem handshake, one-entry skid, IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          StallF,
  input  logic          StallD,
  input  logic          PCSrcD,
  input  logic [31:0]   PCBranchD,
  fetch_stage_if.master imem,
  output logic [31:0]   PCF,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCPlus4D,
  output logic          ValidD
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] pcf_q;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;
  logic [31:0] saved_tgt;

  logic        stall;
  logic        redirect;
  logic        accept;
  logic [31:0] target;
  logic [31:0] pc_next4;

  assign stall    = StallF | StallD;
  assign redirect = PCSrcD & ~stall;
  assign accept   = req_q & imem.ImemReady;
  assign target   = {PCBranchD[31:2], 2'b00};
  assign pc_next4 = pcf_q + 32'd4;

  assign imem.ImemReq  = req_q;
  assign imem.ImemAddr = pcf_q;
  assign PCF           = pcf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      pcf_q      <= RESET_PC;
      InstrD     <= 32'd0;
      PCPlus4D   <= 32'd0;
      ValidD     <= 1'b0;
      skid_instr <= 32'd0;
      skid_pc4   <= 32'd0;
      saved_tgt  <= 32'd0;
    end else begin
      // Bubble by default whenever IF/ID is free to move; specific cases below load a real word.
      if (!stall) begin
        InstrD   <= 32'd0;
        PCPlus4D <= 32'd0;
        ValidD   <= 1'b0;
      end
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (accept) begin
            if (redirect) begin
              pcf_q <= target;
            end else if (stall) begin
              skid_instr <= imem.ImemRData;
              skid_pc4   <= pc_next4;
              pcf_q      <= pc_next4;
              state      <= HOLD;
              req_q      <= 1'b0;
            end else begin
              InstrD   <= imem.ImemRData;
              PCPlus4D <= pc_next4;
              ValidD   <= 1'b1;
              pcf_q    <= pc_next4;
            end
          end else if (redirect) begin
            // The in-flight request must still complete at the held address before retargeting.
            saved_tgt <= target;
            state     <= DISCARD;
          end
        end
        HOLD: begin
          if (redirect) begin
            pcf_q <= target;
            state <= FETCH;
            req_q <= 1'b1;
          end else if (!stall) begin
            InstrD   <= skid_instr;
            PCPlus4D <= skid_pc4;
            ValidD   <= 1'b1;
            state    <= FETCH;
            req_q    <= 1'b1;
          end
        end
        DISCARD: begin
          if (accept) begin
            pcf_q <= redirect ? target : saved_tgt;
            state <= FETCH;
          end else if (redirect) begin
            saved_tgt <= target;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized and directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic        StallF;
  logic        StallD;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .StallD    (StallD),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .imem      (imem_bus.master),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: where the fetch stream is, what is parked, what decode holds.
  logic [31:0] m_pc, m_dtgt, m_instr, m_pc4;
  bit          m_started, m_drop, m_valid;
  logic [63:0] m_buf[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a;
  endfunction

  task automatic m_bubble();
    m_instr = 32'd0;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
  endtask

  task automatic model_step();
    bit st, rd, acc;
    logic [31:0] tgt, w;
    if (!rst_n) begin
      m_pc = 32'h0040_0000; m_started = 0; m_drop = 0; m_dtgt = 0;
      m_buf.delete();
      m_bubble();
      return;
    end
    st  = StallF | StallD;
    rd  = PCSrcD & ~st;
    tgt = PCBranchD & 32'hFFFF_FFFC;
    acc = m_started && (m_buf.size() == 0) && imem_bus.ImemReady;
    w   = mem_word(m_pc);
    if (!m_started) begin
      m_started = 1;
      if (!st) m_bubble();
    end else if (m_buf.size() != 0) begin
      if (rd) begin
        m_buf.delete(); m_pc = tgt; m_bubble();
      end else if (!st) begin
        {m_instr, m_pc4} = m_buf.pop_front();
        m_valid = 1;
      end
    end else if (m_drop) begin
      if (rd) m_dtgt = tgt;
      if (acc) begin m_pc = m_dtgt; m_drop = 0; end
      if (!st) m_bubble();
    end else if (acc) begin
      if (rd) begin
        m_pc = tgt; m_bubble();
      end else if (st) begin
        m_buf.push_back({w, m_pc + 32'd4}); m_pc = m_pc + 32'd4;
      end else begin
        m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4;
      end
    end else if (rd) begin
      m_drop = 1; m_dtgt = tgt; m_bubble();
    end else if (!st) begin
      m_bubble();
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ImemReq",  {31'd0, imem_bus.ImemReq}, {31'd0, (m_started && m_buf.size() == 0)});
      chk("ImemAddr", imem_bus.ImemAddr, m_pc);
      chk("PCF",      PCF, m_pc);
      chk("ValidD",   {31'd0, ValidD}, {31'd0, m_valid});
      chk("InstrD",   InstrD, m_instr);
      chk("PCPlus4D", PCPlus4D, m_pc4);
    end
  end

  task automatic cyc(input bit rn, input bit r, input bit sf, input bit sd,
                     input bit ps, input logic [31:0] tg);
    @(negedge clk);
    rst_n = rn; StallF = sf; StallD = sd; PCSrcD = ps; PCBranchD = tg;
    imem_bus.ImemReady = r;
    imem_bus.ImemRData = r ? mem_word(imem_bus.ImemAddr) : $urandom;
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    #2;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    rst_n = 0; StallF = 0; StallD = 0; PCSrcD = 0; PCBranchD = 0;
    imem_bus.ImemReady = 0; imem_bus.ImemRData = 0;

    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    lit("rst_pcf", PCF, 32'h0040_0000);
    lit("rst_req", {31'd0, imem_bus.ImemReq}, 0);
    lit("rst_valid", {31'd0, ValidD}, 0);
    lit("rst_instr", InstrD, 0);
    lit("rst_pc4", PCPlus4D, 0);

    cyc(1, 1, 0, 0, 0, 0);
    lit("t1_req", {31'd0, imem_bus.ImemReq}, 1);
    lit("t1_addr0", imem_bus.ImemAddr, 32'h0040_0000);
    cyc(1, 1, 0, 0, 0, 0);
    lit("t1_instr", InstrD, 32'h0040_0000);
    lit("t1_pc4", PCPlus4D, 32'h0040_0004);
    lit("t1_valid", {31'd0, ValidD}, 1);
    lit("t1_addr1", imem_bus.ImemAddr, 32'h0040_0004);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      lit("t2_addr_hold", imem_bus.ImemAddr, 32'h0040_0004);
      lit("t2_bubble", {31'd0, ValidD}, 0);
    end
    cyc(1, 1, 0, 0, 0, 0);
    lit("t2_instr", InstrD, 32'h0040_0004);
    lit("t2_addr", imem_bus.ImemAddr, 32'h0040_0008);

    cyc(1, 1, 1, 1, 0, 0);
    lit("t3_hold_instr", InstrD, 32'h0040_0004);
    lit("t3_hold_req", {31'd0, imem_bus.ImemReq}, 0);
    cyc(1, 1, 1, 1, 0, 0);
    lit("t3_hold_instr2", InstrD, 32'h0040_0004);
    cyc(1, 1, 0, 0, 0, 0);
    lit("t3_release_instr", InstrD, 32'h0040_0008);
    lit("t3_release_addr", imem_bus.ImemAddr, 32'h0040_000C);
    lit("t3_release_req", {31'd0, imem_bus.ImemReq}, 1);
    cyc(1, 1, 0, 0, 0, 0);
    lit("t3_once", InstrD, 32'h0040_000C);

    cyc(1, 1, 0, 0, 1, 32'h0040_0103);
    lit("t4_addr", imem_bus.ImemAddr, 32'h0040_0100);
    lit("t4_squash", {31'd0, ValidD}, 0);
    lit("t4_instr", InstrD, 0);
    cyc(1, 1, 0, 0, 0, 0);
    lit("t4_target_word", InstrD, 32'h0040_0100);
    lit("t4_pc4", PCPlus4D, 32'h0040_0104);

    cyc(1, 0, 0, 0, 1, 32'h0040_0200);
    lit("t5_addr_wait", imem_bus.ImemAddr, 32'h0040_0104);
    lit("t5_req", {31'd0, imem_bus.ImemReq}, 1);
    cyc(1, 0, 1, 1, 1, 32'h0040_0300);
    lit("t5_stalled_redirect", imem_bus.ImemAddr, 32'h0040_0104);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    lit("t5_retarget", imem_bus.ImemAddr, 32'h0040_0200);
    lit("t5_dropped", {31'd0, ValidD}, 0);
    cyc(1, 1, 0, 0, 0, 0);
    lit("t5_target_word", InstrD, 32'h0040_0200);

    cyc(1, 1, 1, 1, 0, 0);
    lit("t6_hold_req", {31'd0, imem_bus.ImemReq}, 0);
    cyc(0, 1, 0, 0, 0, 0);
    lit("t6_rst_pcf", PCF, 32'h0040_0000);
    lit("t6_rst_valid", {31'd0, ValidD}, 0);
    lit("t6_rst_instr", InstrD, 0);
    lit("t6_rst_req", {31'd0, imem_bus.ImemReq}, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    lit("t6_restart", InstrD, 32'h0040_0000);

    cyc(1, 1, 0, 0, 1, 32'hFFFF_FFFF);
    lit("wrap_target", PCF, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 0, 0, 0);
    lit("wrap_pcf", PCF, 32'h0000_0000);
    lit("wrap_instr", InstrD, 32'hFFFF_FFFC);
    lit("wrap_pc4", PCPlus4D, 32'h0000_0000);

    for (int i = 0; i < 4000; i++) begin
      bit rn, r, sf, sd, ps;
      logic [31:0] tg;
      rn = ($urandom % 250) != 0;
      r  = ($urandom % 4) != 0;
      sf = ($urandom % 6) == 0;
      sd = ($urandom % 12) == 0 ? ~sf : sf;
      ps = ($urandom % 7) == 0;
      tg = ($urandom % 4) == 0 ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      cyc(rn, r, sf, sd, ps, tg);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
